// File: rtl/core_pkg.sv
// Shared instruction-word layout and sequencer state encoding
// for the attention core and its instruction sequencer.
package core_pkg;

  localparam int INST_W          = 17;
  localparam int INST_OFIFO_RD   = 16;
  localparam int INST_QK_ADD_MSB = 15;
  localparam int INST_QK_ADD_LSB = 12;
  localparam int INST_P_ADD_MSB  = 11;
  localparam int INST_P_ADD_LSB  = 8;
  localparam int INST_EXEC       = 7;
  localparam int INST_LOAD       = 6;
  localparam int INST_QRD        = 5;
  localparam int INST_QWR        = 4;
  localparam int INST_KRD        = 3;
  localparam int INST_KWR        = 2;
  localparam int INST_PRD        = 1;
  localparam int INST_PWR        = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLD,
    S_PAD,
    S_EXE,
    S_WB,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_inst_seq_if.sv
// Host/core handshake bundle seen by the instruction sequencer.
// master = sequencer side, slave = host/core side.
interface core_inst_seq_if;
  import core_pkg::*;

  logic              start;
  logic              data_valid;
  logic              data_ready;
  logic              fifo_valid;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    input  start, data_valid, fifo_valid,
    output data_ready, inst, busy, done
  );

  modport slave (
    output start, data_valid, fifo_valid,
    input  data_ready, inst, busy, done
  );

endinterface

// File: rtl/core_inst_seq.sv
// Per-tile instruction sequencer: Q/K writes, kernel load, pad,
// execute, then ofifo drain into psum memory.
module core_inst_seq
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     col,
  input  logic [7:0]     len_q,
  input  logic [7:0]     load_pad,
  core_inst_seq_if.master bus
);

  state_t            state;
  state_t            nxt;
  logic [7:0]        cnt;
  logic [7:0]        cnt_d;
  logic [7:0]        rd_cnt;
  logic [7:0]        rd_d;
  logic [7:0]        wr_cnt;
  logic [7:0]        wr_d;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] inst_d;
  logic              rdy_q;
  logic              rdy_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  // pmem_wr trails ofifo_rd by one cycle, so WB exits on the
  // cycle whose registered read is the last outstanding one.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (bus.start) nxt = S_QWR;
      S_QWR:
        if (bus.data_valid && cnt == len_q - 8'd1)
          nxt = S_KWR;
      S_KWR:
        if (bus.data_valid && cnt == col - 8'd1)
          nxt = S_KLD;
      S_KLD:
        if (cnt == col)
          nxt = (load_pad == 8'd0) ? S_EXE : S_PAD;
      S_PAD:
        if (cnt == load_pad - 8'd1) nxt = S_EXE;
      S_EXE:
        if (cnt == len_q) nxt = S_WB;
      S_WB:
        if (inst_q[INST_OFIFO_RD] &&
            wr_cnt == len_q - 8'd1)
          nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d = '0;
    cnt_d  = cnt;
    rd_d   = rd_cnt;
    wr_d   = wr_cnt;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        rd_d  = '0;
        wr_d  = '0;
      end
      S_QWR:
        if (bus.data_valid) begin
          inst_d[INST_QWR] = 1'b1;
          inst_d[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = cnt[3:0];
          cnt_d = cnt + 8'd1;
        end
      S_KWR:
        if (bus.data_valid) begin
          inst_d[INST_KWR] = 1'b1;
          inst_d[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = cnt[3:0];
          cnt_d = cnt + 8'd1;
        end
      S_KLD: begin
        inst_d[INST_LOAD] = 1'b1;
        if (cnt < col) begin
          inst_d[INST_KRD] = 1'b1;
          inst_d[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = cnt[3:0];
        end
        cnt_d = cnt + 8'd1;
      end
      S_PAD: cnt_d = cnt + 8'd1;
      S_EXE: begin
        inst_d[INST_EXEC] = 1'b1;
        if (cnt < len_q) begin
          inst_d[INST_QRD] = 1'b1;
          inst_d[INST_QK_ADD_MSB:INST_QK_ADD_LSB] = cnt[3:0];
        end
        cnt_d = cnt + 8'd1;
      end
      S_WB: begin
        if (bus.fifo_valid && rd_cnt < len_q) begin
          inst_d[INST_OFIFO_RD] = 1'b1;
          rd_d = rd_cnt + 8'd1;
        end
        if (inst_q[INST_OFIFO_RD]) begin
          inst_d[INST_PWR] = 1'b1;
          inst_d[INST_P_ADD_MSB:INST_P_ADD_LSB] = wr_cnt[3:0];
          wr_d = wr_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    if (nxt != state) cnt_d = '0;
    rdy_d  = (nxt == S_QWR) || (nxt == S_KWR);
    busy_d = (nxt != S_IDLE) || (state == S_DONE);
    done_d = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      inst_q <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      rd_cnt <= rd_d;
      wr_cnt <= wr_d;
      inst_q <= inst_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.inst       = inst_q;
  assign bus.data_ready = rdy_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: per-cycle trace model of a
// tile built from phase lengths plus literal pins on the model.
module tb_core_inst_seq;
  import core_pkg::*;

  localparam int N = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] col;
  logic [7:0] len_q;
  logic [7:0] load_pad;

  core_inst_seq_if bus();

  core_inst_seq dut (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .len_q    (len_q),
    .load_pad (load_pad),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [16:0] exp_inst [N];
  bit exp_rdy  [N];
  bit exp_busy [N];
  bit exp_done [N];
  bit dv_pat   [N];
  bit fv_pat   [N];
  bit st_pat   [N];

  int n_qwr, n_kwr, n_load, n_exec, n_pwr, n_ord;
  int n_done, done_at;
  bit prev_rd;
  int last;

  function automatic logic [16:0] qk(input int a);
    logic [16:0] v;
    v = '0;
    v[15:12] = a[3:0];
    return v;
  endfunction

  function automatic logic [16:0] pa(input int a);
    logic [16:0] v;
    v = '0;
    v[11:8] = a[3:0];
    return v;
  endfunction

  // Cycle k = k-th cycle after the edge that samples start.
  task automatic build(input int lq, input int cl,
                       input int pad, output int fin);
    int c, n, s, r, lim;
    for (int i = 0; i < N; i++) begin
      exp_inst[i] = '0;
      exp_rdy[i]  = 1'b0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
    c = 0;
    for (int ph = 0; ph < 2; ph++) begin
      n = 0;
      lim = (ph == 0) ? lq : cl;
      while (n < lim) begin
        exp_rdy[c] = 1'b1;
        if (dv_pat[c]) begin
          exp_inst[c+1] = qk(n) |
            ((ph == 0) ? 17'h00010 : 17'h00004);
          n++;
        end
        c++;
      end
    end
    for (int i = 0; i <= cl; i++)
      exp_inst[c+1+i] = 17'h00040 |
        ((i < cl) ? (qk(i) | 17'h00008) : 17'h0);
    s = c + cl + 1 + pad;
    for (int i = 0; i <= lq; i++)
      exp_inst[s+1+i] = 17'h00080 |
        ((i < lq) ? (qk(i) | 17'h00020) : 17'h0);
    c = s + lq + 1;
    r = 0;
    while (r < lq) begin
      if (fv_pat[c]) begin
        exp_inst[c+1] = exp_inst[c+1] | 17'h10000;
        exp_inst[c+2] = exp_inst[c+2] | pa(r) | 17'h00001;
        r++;
      end
      c++;
    end
    fin = c + 2;
    exp_done[fin] = 1'b1;
    for (int i = 0; i <= fin; i++) exp_busy[i] = 1'b1;
  endtask

  task automatic chk(input string name, input int act,
                     input int want);
    vec++;
    if (act != want) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic drive(input int k);
    bus.data_valid = dv_pat[k];
    bus.fifo_valid = fv_pat[k];
    bus.start      = st_pat[k];
  endtask

  task automatic fill(input bit dv, input bit fv);
    for (int i = 0; i < N; i++) begin
      dv_pat[i] = dv;
      fv_pat[i] = fv;
      st_pat[i] = 1'b0;
    end
  endtask

  task automatic run_tile(input int lq, input int cl,
                          input int pad, input int abort_at,
                          output int fin);
    len_q    = 8'(lq);
    col      = 8'(cl);
    load_pad = 8'(pad);
    build(lq, cl, pad, fin);
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 cyc = 0;
    drive(0);
    chk_en = 1'b1;
    for (int k = 1; k <= fin + 3; k++) begin
      if (k == abort_at) begin
        @(negedge clk);
        #2 chk_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort inst", int'(bus.inst), 0);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort ready", int'(bus.data_ready), 0);
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          chk("abort done", int'(bus.done), 0);
        end
        #2 reset = 1'b1;
        break;
      end
      @(posedge clk);
      #1 cyc = k;
      drive(k);
    end
    @(posedge clk);
    #1 chk_en = 1'b0;
    bus.data_valid = 1'b0;
    bus.fifo_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == 0) begin
        n_qwr = 0; n_kwr = 0; n_load = 0; n_exec = 0;
        n_pwr = 0; n_ord = 0; n_done = 0;
        done_at = -1;
        prev_rd = 1'b0;
      end
      vec++;
      if (bus.inst !== exp_inst[cyc] ||
          bus.data_ready !== exp_rdy[cyc] ||
          bus.busy !== exp_busy[cyc] ||
          bus.done !== exp_done[cyc]) begin
        miss++;
        $display("FAIL cycle %0d: inst=%05h rdy=%b busy=%b done=%b want inst=%05h rdy=%b busy=%b done=%b",
                 cyc, bus.inst, bus.data_ready, bus.busy,
                 bus.done, exp_inst[cyc], exp_rdy[cyc],
                 exp_busy[cyc], exp_done[cyc]);
      end
      vec++;
      if ($countones(bus.inst[5:2]) > 1 ||
          bus.inst[1] !== 1'b0) begin
        miss++;
        $display("FAIL exclusive cycle %0d: inst=%05h",
                 cyc, bus.inst);
      end
      vec++;
      if (bus.inst[0] !== prev_rd) begin
        miss++;
        $display("FAIL rd->wr lag cycle %0d: pmem_wr=%b want %b",
                 cyc, bus.inst[0], prev_rd);
      end
      prev_rd = bus.inst[16];
      n_qwr  += int'(bus.inst[4]);
      n_kwr  += int'(bus.inst[2]);
      n_load += int'(bus.inst[6]);
      n_exec += int'(bus.inst[7]);
      n_pwr  += int'(bus.inst[0]);
      n_ord  += int'(bus.inst[16]);
      if (bus.done) begin
        n_done++;
        done_at = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.data_valid = 1'b0;
    bus.fifo_valid = 1'b0;
    col = 8'd8;
    len_q = 8'd8;
    load_pad = 8'd8;
    fill(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset inst", int'(bus.inst), 0);
    chk("reset ready", int'(bus.data_ready), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    reset = 1'b1;

    run_tile(8, 8, 8, 0, last);
    chk("A model done", last, 52);
    chk("A done cycle", done_at, 52);
    chk("A qmem_wr", n_qwr, 8);
    chk("A kmem_wr", n_kwr, 8);
    chk("A load", n_load, 9);
    chk("A exec", n_exec, 9);
    chk("A pmem_wr", n_pwr, 8);
    chk("A done count", n_done, 1);

    fill(1'b1, 1'b1);
    for (int i = 0; i < N; i++) dv_pat[i] = (i % 2 == 0);
    run_tile(8, 8, 8, 0, last);
    chk("B model done", last, 67);
    chk("B done cycle", done_at, 67);
    chk("B qmem_wr", n_qwr, 8);
    chk("B kmem_wr", n_kwr, 8);

    fill(1'b1, 1'b1);
    for (int i = 45; i <= 49; i++) fv_pat[i] = 1'b0;
    run_tile(8, 8, 8, 0, last);
    chk("C model done", last, 57);
    chk("C done cycle", done_at, 57);
    chk("C ofifo_rd", n_ord, 8);
    chk("C pmem_wr", n_pwr, 8);

    fill(1'b1, 1'b1);
    st_pat[37] = 1'b1;
    run_tile(8, 8, 8, 0, last);
    chk("D done count", n_done, 1);
    chk("D done cycle", done_at, 52);

    fill(1'b1, 1'b1);
    run_tile(4, 3, 0, 0, last);
    chk("E model done", last, 22);
    chk("E done cycle", done_at, 22);
    chk("E load", n_load, 4);
    chk("E exec", n_exec, 5);

    fill(1'b1, 1'b1);
    run_tile(8, 8, 8, 19, last);

    fill(1'b1, 1'b1);
    run_tile(8, 8, 8, 0, last);
    chk("G done cycle", done_at, 52);
    chk("G qmem_wr", n_qwr, 8);
    chk("G done count", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule

// File: doc/core_inst_seq.md
# core_inst_seq

Instruction sequencer for one attention core. It drives the 17-bit `inst` word that the core decodes. For each tile it runs the full flow: write Q rows, write K rows, load K into the MAC array, stream Q through execute, then drain the output FIFO into psum memory. It sits between the testbench/host data stream (`mem_in` producer) and the core, and replaces hand-written instruction sequences.

## Interface
- `col`, 8, MAC array columns; number of K rows loaded.
- `len_q`, 8, Q rows per tile; also psum rows written; 1..16.
- `load_pad`, 8, idle cycles between kernel load and execute (array settle).
- `clk`  in  1  core clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces IDLE and clears all outputs.
- `start`  in  1  one-cycle request to run one tile; sampled only in IDLE.
- `data_valid`  in  1  producer has a valid `mem_in` row this cycle.
- `data_ready`  out  1  sequencer consumes the `mem_in` row this cycle (write enable issued).
- `fifo_valid`  in  1  ofifo `o_valid`; at least one full row is readable.
- `inst`  out  17  core instruction word: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] kernel load / kmem select, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at tile completion.

## Operation
- Reset value: `inst`=0, `data_ready`=0, `busy`=0, `done`=0, all counters 0, state IDLE.
- States:
  - IDLE → QWR on `start`.
  - QWR: `data_ready`=1. Each cycle with `data_valid`=1: qmem_wr=1, qkmem_add=cnt, cnt++. After `len_q` writes → KWR, cnt=0.
  - KWR: same as QWR with kmem_wr, for `col` writes → KLD.
  - KLD: cycles 0..col-1 issue kmem_rd=1, qkmem_add=cycle. inst[6]=1 for cycles 0..col, i.e. col+1 cycles, covering the 1-cycle SRAM read latency. → PAD.
  - PAD: `load_pad` cycles of `inst`=0 → EXE.
  - EXE: cycles 0..len_q-1 issue qmem_rd=1, qkmem_add=cycle. inst[7]=1 for len_q+1 cycles. → WB.
  - WB: each cycle with `fifo_valid`=1 and rd_cnt<len_q: ofifo_rd=1, rd_cnt++. The cycle after each ofifo_rd: pmem_wr=1, pmem_add=wr_cnt, wr_cnt++. When wr_cnt reaches len_q → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Unused `inst` bits are 0 in every state. pmem_rd is never driven by this block (always 0).
- `start` while busy is ignored; it is not queued.
- `data_valid`=0 in QWR/KWR stalls the write counter with no write issued. There is no timeout.
- pmem_wr is a registered copy of ofifo_rd, so a pmem_wr from the last read may coincide with WB exit. DONE is entered only after that write issues.
- Address fields are 4 bits and zero-extended. With `len_q`≤8 and `col`≤8, bit 3 is always 0.
- Asserting `reset` mid-tile aborts immediately: no partial `done`, outputs return to reset values. Memory contents are left as written.

## Timing
- All outputs are registered and change only on `clk` rising edge, except for the asynchronous reset.
- start→first qmem_wr: 1 cycle (IDLE→QWR on edge N, write visible in cycle N+1 if `data_valid`).
- Minimum tile latency with continuous data and `fifo_valid` never stalling: 1 + len_q + col + (col+1) + load_pad + (len_q+1) + len_q + 1 + 1 cycles.
- ofifo_rd→pmem_wr: exactly 1 cycle. pmem_add matches the read order 0..len_q-1.
- `done` is high in exactly one cycle; `busy` falls the cycle after `done`.

## Structure
- Shared package `core_pkg`: inst bit-position constants (`INST_OFIFO_RD`=16, `INST_QK_ADD_MSB/LSB`=15/12, `INST_P_ADD_MSB/LSB`=11/8, `INST_EXEC`=7, `INST_LOAD`=6, `INST_QRD`..`INST_PWR`=5..0) and the state encoding typedef. The core decoder uses the same constants.
- Single module; no sub-module. The counters (phase cnt, rd_cnt, wr_cnt) live inline.

## Test plan
- Reset then `start` with `data_valid` held 1, `len_q`=8, `col`=8, `load_pad`=8, `fifo_valid`=1 after EXE → qmem_wr at addr 0..7, kmem_wr at 0..7, inst[6] high 9 cycles, inst[7] high 9 cycles, pmem_wr at 0..7, `done` at cycle count matching the Timing formula.
- `data_valid` toggling 1,0,1,0 in QWR → exactly 8 qmem_wr, addresses contiguous, no write on stalled cycles.
- `fifo_valid` low for 5 cycles mid-WB → ofifo_rd pauses; each pmem_wr still follows its ofifo_rd by 1 cycle; 8 writes total.
- `start` pulsed during EXE → ignored; one `done` only; next `start` in IDLE runs a fresh tile from qmem addr 0.
- `reset`=0 asserted during KLD, then released → `inst`=0 and `busy`=0 immediately; no `done`; a new `start` restarts at QWR.
- Check every cycle: at most one of qmem_wr/kmem_wr/qmem_rd/kmem_rd is high, and pmem_rd is always 0.
